// File: rtl/led_seq_master.sv
// led_seq_master: autonomous AXI4-Lite write master that periodically pushes an
// 8-bit LED pattern into a single slave register and steps the pattern by mode.
module led_seq_master #(
    parameter int unsigned                   C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned                   C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_TARGET_ADDR      = '0,
    parameter int unsigned                   C_TICK_DIV         = 50_000_000
) (
    input  logic                            m_axi_aclk,
    input  logic                            m_axi_aresetn,
    input  logic                            enable,
    input  logic [1:0]                      mode,
    input  logic [7:0]                      pattern_in,
    output logic                            busy,
    output logic                            error,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                      m_axi_awprot,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready
);

    localparam int unsigned STRB_W    = C_M_AXI_DATA_WIDTH / 8;
    localparam int unsigned CNT_W     = 32;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(C_TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                en_q;
    logic                pending_q, pending_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                bready_q, bready_d;
    logic                busy_q, busy_d;
    logic                error_q, error_d;
    logic [7:0]          pattern_q, pattern_d;
    logic                tick_c;
    logic                rise_c;

    assign tick_c = enable && (cnt_q == TICK_LAST);
    assign rise_c = enable && !en_q;

    // Free-running tick divider, held at zero while disabled.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!enable || tick_c) begin
            cnt_d = '0;
        end
    end

    // Next-state, handshake tracking and pattern stepping.
    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        wstrb_d   = wstrb_q;
        bready_d  = bready_q;
        error_d   = error_q;
        pattern_d = pattern_q;
        pending_d = pending_q | tick_c;

        case (state_q)
            ST_IDLE: begin
                if (pending_q && enable) begin
                    state_d   = ST_ISSUE;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    wstrb_d   = '1;
                    pending_d = 1'b0;
                end
            end
            ST_ISSUE: begin
                awvalid_d = awvalid_q && !m_axi_awready;
                wvalid_d  = wvalid_q && !m_axi_wready;
                wstrb_d   = wvalid_d ? '1 : '0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = ST_RESP;
                    bready_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (m_axi_bvalid && bready_q) begin
                    state_d  = ST_IDLE;
                    bready_d = 1'b0;
                    if (m_axi_bresp == 2'b00) begin
                        case (mode)
                            2'd0:    pattern_d = pattern_q + 8'd1;
                            2'd1:    pattern_d = pattern_q - 8'd1;
                            2'd2:    pattern_d = {pattern_q[6:0], pattern_q[7]};
                            default: pattern_d = pattern_in;
                        endcase
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A fresh enable reseeds the pattern and clears the sticky error.
        if (rise_c) begin
            pattern_d = pattern_in;
            error_d   = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            en_q      <= 1'b0;
            pending_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wstrb_q   <= '0;
            bready_q  <= 1'b0;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
            pattern_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            en_q      <= enable;
            pending_q <= pending_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            wstrb_q   <= wstrb_d;
            bready_q  <= bready_d;
            busy_q    <= busy_d;
            error_q   <= error_d;
            pattern_q <= pattern_d;
        end
    end

    assign busy          = busy_q;
    assign error         = error_q;
    assign m_axi_awaddr  = C_TARGET_ADDR;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = C_M_AXI_DATA_WIDTH'(pattern_q);
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_led_seq_master.sv
// Bench for led_seq_master: configurable AXI slave, behavioural reference model
// checked every cycle, plus directed literal sequences and a randomized phase.
`timescale 1ns/1ps
module tb_led_seq_master;

    localparam int unsigned DIV   = 4;
    localparam logic [31:0] TADDR = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  mode;
    logic [7:0]  pattern_in;
    logic        busy;
    logic        error;
    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid;
    logic        awready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0;
    logic        m_axi_bready;

    led_seq_master #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(32),
        .C_TARGET_ADDR     (TADDR),
        .C_TICK_DIV        (DIV)
    ) dut (
        .m_axi_aclk   (clk),
        .m_axi_aresetn(rst_n),
        .enable       (enable),
        .mode         (mode),
        .pattern_in   (pattern_in),
        .busy         (busy),
        .error        (error),
        .m_axi_awaddr (m_axi_awaddr),
        .m_axi_awprot (m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(awready),
        .m_axi_wdata  (m_axi_wdata),
        .m_axi_wstrb  (m_axi_wstrb),
        .m_axi_wvalid (m_axi_wvalid),
        .m_axi_wready (wready),
        .m_axi_bresp  (bresp),
        .m_axi_bvalid (bvalid),
        .m_axi_bready (m_axi_bready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) begin
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
            end
        end
    endtask

    // Pattern step derived directly from the mode rules.
    function automatic logic [7:0] adv(input logic [7:0] p, input logic [1:0] md,
                                       input logic [7:0] pin);
        case (md)
            2'd0:    adv = 8'((int'(p) + 1) % 256);
            2'd1:    adv = 8'((int'(p) + 255) % 256);
            2'd2:    adv = 8'((int'(p) * 2) % 256 + int'(p) / 128);
            default: adv = pin;
        endcase
    endfunction

    // Reference model state: what the outputs must be after the most recent edge.
    logic        m_en_prev, m_pend, m_infl, m_aw, m_w, m_br, m_err;
    logic [7:0]  m_p;
    int unsigned m_run;

    // Slave knobs and bookkeeping.
    int aw_lat = 0, w_lat = 0, b_lat = 0;
    int aw_wait = 0, w_wait = 0, b_wait = 0;
    int b_idx = 0, err_at = -1, err_pct = 0;
    int b_cnt = 0;
    logic [7:0] wr_log[$];

    logic aw_hs, w_hs, b_hs, rise, tick, entry, n_aw, n_w, n_br;

    // Per-cycle compare, slave response and model advance through the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_en_prev = 1'b0; m_pend = 1'b0; m_infl = 1'b0; m_aw = 1'b0;
            m_w = 1'b0; m_br = 1'b0; m_err = 1'b0; m_p = 8'h00; m_run = 0;
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
            aw_wait = 0; w_wait = 0; b_wait = 0;
            chk("rst_awvalid", 32'(m_axi_awvalid), 32'd0);
            chk("rst_wvalid",  32'(m_axi_wvalid),  32'd0);
            chk("rst_bready",  32'(m_axi_bready),  32'd0);
            chk("rst_busy",    32'(busy),          32'd0);
            chk("rst_error",   32'(error),         32'd0);
            chk("rst_wstrb",   32'(m_axi_wstrb),   32'd0);
        end else begin
            chk("awvalid", 32'(m_axi_awvalid), 32'(m_aw));
            chk("wvalid",  32'(m_axi_wvalid),  32'(m_w));
            chk("bready",  32'(m_axi_bready),  32'(m_br));
            chk("busy",    32'(busy),          32'(m_infl));
            chk("error",   32'(error),         32'(m_err));
            chk("wstrb",   32'(m_axi_wstrb),   m_w ? 32'hF : 32'h0);
            chk("wdata",   m_axi_wdata,        32'(m_p));
            chk("awaddr",  m_axi_awaddr,       TADDR);
            chk("awprot",  32'(m_axi_awprot),  32'd0);

            if (m_axi_awvalid) begin
                awready = (aw_wait >= aw_lat);
                aw_wait = awready ? 0 : aw_wait + 1;
            end else begin
                awready = 1'b0; aw_wait = 0;
            end
            if (m_axi_wvalid) begin
                wready = (w_wait >= w_lat);
                w_wait = wready ? 0 : w_wait + 1;
            end else begin
                wready = 1'b0; w_wait = 0;
            end
            if (m_axi_bready) begin
                if (b_wait >= b_lat) begin
                    bvalid = 1'b1;
                    bresp  = ((b_idx == err_at) || (int'($urandom_range(99)) < err_pct))
                             ? 2'b10 : 2'b00;
                end else begin
                    bvalid = 1'b0; bresp = 2'b00; b_wait++;
                end
            end else begin
                bvalid = 1'b0; bresp = 2'b00; b_wait = 0;
            end

            aw_hs = m_aw && awready;
            w_hs  = m_w && wready;
            b_hs  = m_br && bvalid;
            if (w_hs) wr_log.push_back(m_axi_wdata[7:0]);
            rise  = enable && !m_en_prev;
            tick  = enable && ((m_run % DIV) == DIV - 1);
            entry = !m_infl && m_pend && enable;
            n_aw  = entry || (m_aw && !aw_hs);
            n_w   = entry || (m_w && !w_hs);
            n_br  = m_br ? !bvalid : (m_infl && !n_aw && !n_w);
            if (b_hs) begin
                b_cnt++; b_idx++;
                if (bresp == 2'b00) m_p = adv(m_p, mode, pattern_in);
                else                m_err = 1'b1;
            end
            if (rise) begin
                m_p = pattern_in; m_err = 1'b0;
            end
            m_pend    = (m_pend || tick) && !entry;
            m_run     = enable ? m_run + 1 : 0;
            m_infl    = entry ? 1'b1 : (b_hs ? 1'b0 : m_infl);
            m_aw      = n_aw;
            m_w       = n_w;
            m_br      = n_br;
            m_en_prev = enable;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int c = 0;
        while (wr_log.size() < n && c < budget) begin
            step(1);
            c++;
        end
        chk(name, 32'(wr_log.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while (busy && c < budget) begin
            step(1);
            c++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_aw(input int budget);
        int c = 0;
        while (!m_axi_awvalid && c < budget) begin
            step(1);
            c++;
        end
        chk("awvalid_timeout", 32'(m_axi_awvalid), 32'd1);
    endtask

    // Compare the first n logged writes with bytes packed MSB-first into vals.
    task automatic check_seq(input string name, input logic [31:0] vals, input int n);
        logic [31:0] v;
        for (int i = 0; i < n; i++) begin
            v = vals >> (24 - 8 * i);
            chk(name, (i < wr_log.size()) ? 32'(wr_log[i]) : 32'hDEAD, 32'(v[7:0]));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int b0;
        rst_n = 1'b0; enable = 1'b1; mode = 2'd0; pattern_in = 8'hFE;
        step(5);

        // Release reset with enable held: first awvalid after DIV+1 edges.
        rst_n = 1'b1;
        first = 0;
        for (int i = 1; i <= 20 && first == 0; i++) begin
            step(1);
            if (m_axi_awvalid) first = i;
        end
        chk("first_aw_latency", 32'(first), 32'(DIV + 1));

        // Count-up from 0xFE through the wrap.
        wait_writes(4, 100, "countup_timeout");
        check_seq("countup_seq", 32'hFEFF_0001, 4);
        enable = 1'b0;
        wait_idle(50);

        // Skewed readies: AW early, then W early.
        wr_log.delete();
        b0 = b_cnt;
        aw_lat = 0; w_lat = 3; mode = 2'd0; pattern_in = 8'h10;
        step(2);
        enable = 1'b1;
        wait_writes(2, 200, "skew1_timeout");
        aw_lat = 3; w_lat = 0;
        wait_writes(4, 200, "skew2_timeout");
        enable = 1'b0;
        wait_idle(50);
        check_seq("skew_seq", 32'h1011_1213, 4);
        chk("skew_b_per_write", 32'(b_cnt - b0), 32'(wr_log.size()));

        // SLVERR on the second write, rotate-left from 0x01.
        wr_log.delete();
        aw_lat = 0; w_lat = 0; b_lat = 0; mode = 2'd2; pattern_in = 8'h01;
        err_at = b_idx + 1;
        step(2);
        enable = 1'b1;
        wait_writes(4, 200, "slverr_timeout");
        enable = 1'b0;
        wait_idle(50);
        err_at = -1;
        check_seq("slverr_seq", 32'h0102_0204, 4);
        chk("error_sticky", 32'(error), 32'd1);
        step(3);
        chk("error_held", 32'(error), 32'd1);
        enable = 1'b1;
        step(2);
        chk("error_cleared", 32'(error), 32'd0);
        enable = 1'b0;
        step(1);
        wait_idle(50);

        // Enable dropped while awvalid waits on a slow awready.
        wr_log.delete();
        aw_lat = 5; mode = 2'd0; pattern_in = 8'h40;
        step(2);
        enable = 1'b1;
        wait_aw(50);
        enable = 1'b0;
        wait_idle(50);
        step(20);
        chk("drop_write_count", 32'(wr_log.size()), 32'd1);
        check_seq("drop_seq", 32'h4000_0000, 1);

        // Ticks much faster than a slow B response, count down from 0x00.
        wr_log.delete();
        aw_lat = 0; b_lat = 10; mode = 2'd1; pattern_in = 8'h00;
        step(2);
        enable = 1'b1;
        wait_writes(3, 300, "fast_timeout");
        enable = 1'b0;
        wait_idle(100);
        check_seq("fast_seq", 32'h00FF_FE00, 3);

        // Reset asserted mid-transaction clears outputs immediately.
        aw_lat = 4; b_lat = 0; mode = 2'd0; pattern_in = 8'h77;
        enable = 1'b1;
        wait_aw(50);
        step(1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_awvalid", 32'(m_axi_awvalid), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        step(2);
        enable = 1'b0;
        rst_n  = 1'b1;
        step(3);

        // Randomized traffic against the model.
        err_pct = 10;
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(15) == 0) begin
                aw_lat = int'($urandom_range(4));
                w_lat  = int'($urandom_range(4));
                b_lat  = int'($urandom_range(6));
            end
            if ($urandom_range(31) == 0) mode = 2'($urandom);
            if ($urandom_range(7) == 0) pattern_in = 8'($urandom);
            if (!busy && $urandom_range(40) == 0) enable = !enable;
            step(1);
        end
        enable  = 1'b0;
        err_pct = 0;
        wait_idle(100);
        step(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_seq_master.md
# led_seq_master

AXI4-Lite write-only master that drives the `my_led_v1_0` LED peripheral autonomously. Every `C_TICK_DIV` clock cycles while enabled it writes the current 8-bit LED pattern to slave register `C_TARGET_ADDR`, then advances the pattern according to `mode`. It sits between the fabric-side control pins and the LED IP's `s_axi_*` slave port, replacing software-driven register writes.

## Interface
- `C_M_AXI_ADDR_WIDTH`, 32, AXI address width.
- `C_M_AXI_DATA_WIDTH`, 32, AXI data width (32 only).
- `C_TARGET_ADDR`, 32'h0, byte address of the LED register (slv_reg0).
- `C_TICK_DIV`, 50_000_000, cycles between write requests; legal range 2..2^32-1.
- `m_axi_aclk`  in  1  clock.
- `m_axi_aresetn`  in  1  reset; one clock, asynchronous assert, active-low.
- `enable`  in  1  sequencer run; level-sensitive.
- `mode`  in  2  0 count up, 1 count down, 2 rotate left, 3 fixed `pattern_in`.
- `pattern_in`  in  8  seed loaded on enable rising edge; mode-3 value.
- `busy`  out  1  AXI transaction in flight (ISSUE or RESP).
- `error`  out  1  sticky: a response other than OKAY was received.
- `m_axi_awaddr`  out  C_M_AXI_ADDR_WIDTH  always `C_TARGET_ADDR`.
- `m_axi_awprot`  out  3  constant 0.
- `m_axi_awvalid` / `m_axi_awready`  out / in  1  AW handshake.
- `m_axi_wdata`  out  32  {24'b0, pattern}.
- `m_axi_wstrb`  out  4  4'hF while `m_axi_wvalid`, else 0.
- `m_axi_wvalid` / `m_axi_wready`  out / in  1  W handshake.
- `m_axi_bresp`  in  2  write response.
- `m_axi_bvalid` / `m_axi_bready`  in / out  1  B handshake.
- No read channels.

## Operation
- Reset values: all valids, `bready`, `busy`, `error` = 0; `wstrb` = 0; pattern = 8'h00; tick counter = 0; pending = 0; state IDLE.
- Tick counter: runs only while `enable`=1; counts 0..C_TICK_DIV-1, wraps, asserts `tick` for one cycle on the wrap. Cleared when `enable`=0.
- Enable rising edge (registered compare): pattern <= `pattern_in`, `error` <= 0, counter restarts at 0.
- Pending flag: set on `tick`; cleared when ISSUE is entered. Ticks arriving while pending=1 are dropped (no queueing).
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if pending & `enable` -> ISSUE; assert awvalid, wvalid, wstrb=4'hF in the same register update.
- ISSUE: awvalid dropped on the cycle after awvalid&awready; wvalid likewise for W, independently. Order of ready arrival is arbitrary (AW first, W first, or same cycle). When both handshakes are done -> RESP, bready <= 1, wstrb <= 0.
- RESP: on bvalid&bready -> bready <= 0, -> IDLE. If bresp==2'b00 advance pattern; else set `error`, pattern unchanged (same value retried on next tick).
- Pattern advance: mode 0 p+1 (8'hFF wraps to 8'h00); mode 1 p-1 (8'h00 wraps to 8'hFF); mode 2 {p[6:0],p[7]}; mode 3 `pattern_in`. `mode` sampled at response time.
- Valids, once asserted, never drop before their handshake, even if `enable` falls; the transaction always completes, then FSM stays in IDLE.
- Reset mid-transaction: outputs return to reset values immediately; no completion attempted.
- awaddr/wdata stable from ISSUE entry until respective handshake.

## Timing
- First write: valids asserted 1 cycle after the tick cycle (tick registered into pending, IDLE sees it next edge).
- Zero-wait slave (ready high): AW and W complete on first ISSUE cycle; RESP next; bready high until bvalid. Minimum transaction = 3 cycles IDLE->IDLE with bvalid one cycle after handshakes.
- `busy` = (state != IDLE), registered with the state.
- Pattern update visible on `wdata` the cycle after the B handshake.
- C_TICK_DIV shorter than a transaction: excess ticks dropped; write rate limited by slave.

## Test plan
- Reset: hold `m_axi_aresetn`=0 with `enable`=1 -> all valids/bready/busy/error 0, no AXI activity; release -> first awvalid after exactly C_TICK_DIV+1 cycles.
- Count-up with LED IP, C_TICK_DIV=4, `pattern_in`=8'hFE, mode 0 -> writes 0xFE, 0xFF, 0x00, 0x01; `led` follows each value.
- Skewed readies (bench slave): awready 3 cycles before wready, then reversed -> each valid drops exactly one cycle after its own handshake, one B handshake per write, wstrb 4'hF only while wvalid.
- SLVERR: bench returns bresp=2'b10 on 2nd write, mode 2 seed 8'h01 -> writes 0x01, 0x02, 0x02, 0x04; `error`=1 until next enable rising edge.
- Enable dropped while awvalid high, awready held low 5 cycles -> awvalid stays high until handshake, transaction completes, no further writes.
- Fast ticks: C_TICK_DIV=2, slave bvalid delayed 10 cycles -> one write per transaction, no back-to-back valid overlap, mode 1 from 8'h00 gives 0x00, 0xFF, 0xFE.
